// File: rtl/fifo_sync_lvl.sv
// fifo_sync_lvl: single-clock FIFO with level or rising-edge strobes, occupancy
// count, programmable almost-full/almost-empty flags, sticky overflow/underflow
// flags and a synchronous flush that leaves memory contents untouched.
// Optional first-word fall-through read port: define FIFO_SYNC_LVL_FWFT_EN.
module fifo_sync_lvl #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 32,
    parameter int unsigned ADDR_WIDTH    = $clog2(FIFO_DEPTH),
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2,
    parameter int unsigned EDGE_MODE     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  DEPTH_CNT  = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  AFULL_CNT  = CNT_WIDTH'(AFULL_THRESH);
    localparam logic [CNT_WIDTH-1:0]  AEMPTY_CNT = CNT_WIDTH'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic                  we;
    logic                  re;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] wptr_nxt;
    logic [ADDR_WIDTH-1:0] rptr_nxt;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  overflow_nxt;
    logic                  underflow_nxt;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic wr_dly;
            logic rd_dly;

            // Delay taps for rising-edge detection; reset to 0 so a strobe held across reset release counts once.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_dly <= 1'b0;
                    rd_dly <= 1'b0;
                end else begin
                    wr_dly <= wr_en;
                    rd_dly <= rd_en;
                end
            end

            assign we = wr_en & ~wr_dly;
            assign re = rd_en & ~rd_dly;
        end else begin : g_level
            assign we = wr_en;
            assign re = rd_en;
        end
    endgenerate

    // Status flags decoded from the registered occupancy.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_CNT);
    assign almost_empty = (count <= AEMPTY_CNT);

    // Next pointers, occupancy and error flags; flush overrides any strobe.
    always_comb begin
        wr_ok         = 1'b0;
        rd_ok         = 1'b0;
        wptr_nxt      = wptr;
        rptr_nxt      = rptr;
        count_nxt     = count;
        overflow_nxt  = overflow;
        underflow_nxt = underflow;
        if (clr) begin
            wptr_nxt      = '0;
            rptr_nxt      = '0;
            count_nxt     = '0;
            overflow_nxt  = 1'b0;
            underflow_nxt = 1'b0;
        end else begin
            wr_ok = we & ~full;
            rd_ok = re & ~empty;
            if (we && full) begin
                overflow_nxt = 1'b1;
            end
            if (re && empty) begin
                underflow_nxt = 1'b1;
            end
            if (wr_ok) begin
                wptr_nxt = (wptr == LAST_PTR) ? '0 : wptr + PTR_ONE;
            end
            if (rd_ok) begin
                rptr_nxt = (rptr == LAST_PTR) ? '0 : rptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            count     <= count_nxt;
            overflow  <= overflow_nxt;
            underflow <= underflow_nxt;
        end
    end

    // Storage array; not reset, data is invalidated through the pointers.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= din;
        end
    end

`ifdef FIFO_SYNC_LVL_FWFT_EN
    // Head word presented directly; forced to zero while nothing is queued.
    assign dout       = empty ? '0 : mem[rptr];
    assign dout_valid = ~empty;
`else
    // Registered read port: word appears one clock after the accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_ok;
            if (rd_ok) begin
                dout <= mem[rptr];
            end
        end
    end
`endif

endmodule
